// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file write port.
// Load priority with ALU anti-starvation, x0 drop, pending-write scoreboard.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   alu_valid_i/ready_o,
//   alu_addr_i/data_i       : ALU writeback request handshake
//   lsu_valid_i/ready_o,
//   lsu_addr_i/data_i       : load writeback request handshake
//   alloc_i, alloc_addr_i   : decode marks a destination as pending
//   query_addr1/2_i,
//   busy1/2_o               : RAW hazard lookups
//   idle_o                  : no outstanding writes
//   RegWrite_o,
//   register_write_addr_o,
//   register_write_data_o   : registered register-file write port
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  input  logic [4:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  input  logic        alloc_i,
  input  logic [4:0]  alloc_addr_i,
  input  logic [4:0]  query_addr1_i,
  input  logic [4:0]  query_addr2_i,
  output logic        busy1_o,
  output logic        busy2_o,
  output logic        idle_o,
  output logic        RegWrite_o,
  output logic [4:0]  register_write_addr_o,
  output logic [31:0] register_write_data_o
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] MAXW = W'(MAX_WAIT);

  logic [W-1:0] wait_cnt;
  logic [31:0]  busy;
  logic         force_alu;
  logic         xfer;
  logic [4:0]   win_addr;
  logic [31:0]  win_data;
  logic [31:0]  set_mask;
  logic [31:0]  clr_mask;

  always_comb begin
    force_alu   = (wait_cnt == MAXW);
    alu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    if (!rst) begin
      if (alu_valid_i && (!lsu_valid_i || force_alu))
        alu_ready_o = 1'b1;
      else if (lsu_valid_i)
        lsu_ready_o = 1'b1;
    end
  end

  always_comb begin
    xfer     = alu_ready_o | lsu_ready_o;
    win_addr = alu_ready_o ? alu_addr_i : lsu_addr_i;
    win_data = alu_ready_o ? alu_data_i : lsu_data_i;
  end

  // Counts consecutive cycles the ALU waited; saturates so the
  // forced grant stays asserted until the ALU actually transfers.
  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (!alu_valid_i || alu_ready_o)
      wait_cnt <= '0;
    else if (wait_cnt != MAXW)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // An accepted x0 write still consumes the slot but never
  // raises the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite_o            <= 1'b0;
      register_write_addr_o <= '0;
      register_write_data_o <= '0;
    end else begin
      RegWrite_o <= xfer && (win_addr != 5'd0);
      if (xfer) begin
        register_write_addr_o <= win_addr;
        register_write_data_o <= win_data;
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (alloc_i && alloc_addr_i != 5'd0)
      set_mask = 32'd1 << alloc_addr_i;
    if (RegWrite_o)
      clr_mask = 32'd1 << register_write_addr_o;
  end

  // Set is applied after clear: a fresh allocation of the register
  // being committed means a newer producer is still outstanding.
  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
  end

  assign busy1_o = busy[query_addr1_i];
  assign busy2_o = busy[query_addr2_i];
  assign idle_o  = ~|busy;

endmodule
